lsu_request_issuer: RTL and testbench



---
 rtl/lsu_request_issuer.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_request_issuer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_request_issuer.sv
// lsu_request_issuer
//
// Buffers load/store requests from the pipeline in a small FIFO and issues
// them to memory_subsystem with a two-phase handshake: an instruction phase
// (tag + op type) followed by a data phase (address + store value). Issued
// requests are recorded in an outstanding table until their completion
// returns. The table caps concurrency at MAX_OUT and blocks a head request
// whose tag is already in flight. Completions are forwarded to the pipeline
// with the op type recorded at issue; unknown completion tags raise an error
// pulse instead.
//
// Ports
//   clk, rst_N                        clock, async active-low reset
//   req_valid/req_ready               pipeline request handshake
//   req_is_write, req_tag,
//   req_addr, req_value               request payload
//   lsu_proc_instr_valid/_ready       instruction phase handshake
//   lsu_proc_instr_is_write/_tag      instruction phase payload (FIFO head)
//   lsu_proc_data_valid/_ready        data phase handshake
//   lsu_proc_data_tag, lsu_proc_addr,
//   lsu_proc_value                    data phase payload (FIFO head)
//   lsu_completion_valid/_tag/_value  completion from memory_subsystem
//   resp_valid, resp_is_write,
//   resp_tag, resp_value              registered completion to the pipeline
//   err_unexpected_tag                pulse: completion tag not in table
//   outstanding_count                 number of live table entries

module lsu_request_issuer #(
    parameter int TAG_WIDTH = 10,
    parameter int DEPTH     = 4,
    parameter int MAX_OUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_N,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_write,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic [63:0]          req_addr,
    input  logic [63:0]          req_value,
    output logic                 lsu_proc_instr_valid,
    output logic                 lsu_proc_instr_is_write,
    output logic [TAG_WIDTH-1:0] lsu_proc_instr_tag,
    input  logic                 lsu_proc_instr_ready,
    output logic                 lsu_proc_data_valid,
    output logic [TAG_WIDTH-1:0] lsu_proc_data_tag,
    output logic [63:0]          lsu_proc_addr,
    output logic [63:0]          lsu_proc_value,
    input  logic                 lsu_proc_data_ready,
    input  logic                 lsu_completion_valid,
    input  logic [TAG_WIDTH-1:0] lsu_completion_tag,
    input  logic [63:0]          lsu_completion_value,
    output logic                 resp_valid,
    output logic                 resp_is_write,
    output logic [TAG_WIDTH-1:0] resp_tag,
    output logic [63:0]          resp_value,
    output logic                 err_unexpected_tag,
    output logic [4:0]           outstanding_count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

    typedef struct packed {
        logic                 is_write;
        logic [TAG_WIDTH-1:0] tag;
        logic [63:0]          addr;
        logic [63:0]          value;
    } req_t;

    // ---------------- request FIFO ----------------
    req_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_empty, push, pop;
    req_t             head;

    // ---------------- issue FSM / table ----------------
    state_t               state;
    logic                 instr_valid_q, data_valid_q;
    logic [MAX_OUT-1:0]   tbl_valid;
    logic [MAX_OUT-1:0]   tbl_is_write;
    logic [TAG_WIDTH-1:0] tbl_tag [MAX_OUT];
    logic [MAX_OUT-1:0]   free_mask, alloc_mask;
    logic                 tag_busy, hit, hit_is_write, alloc_found, can_issue;

    assign fifo_empty = (fifo_count == '0);
    // Ready comes from the registered count only, so a pop this cycle
    // does not reopen the FIFO until the next cycle.
    assign req_ready  = (fifo_count != (PTR_W+1)'(DEPTH));
    assign push       = req_valid && req_ready;
    assign pop        = data_valid_q && lsu_proc_data_ready;
    assign head       = fifo_empty ? '0 : fifo_mem[rd_ptr];

    // NOTE: payload storage needs no reset; emptiness is tracked by
    // fifo_count and the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{is_write: req_is_write, tag: req_tag,
                                  addr: req_addr, value: req_value};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // CAM lookups against the current table contents. A completion freeing
    // the head's tag this cycle still reports it busy; issue waits a cycle.
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        tag_busy     = 1'b0;
        hit          = 1'b0;
        hit_is_write = 1'b0;
        alloc_found  = 1'b0;
        free_mask    = '0;
        alloc_mask   = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (tbl_valid[i] && tbl_tag[i] == head.tag) tag_busy = 1'b1;
            if (lsu_completion_valid && tbl_valid[i] && tbl_tag[i] == lsu_completion_tag) begin
                hit          = 1'b1;
                hit_is_write = tbl_is_write[i];
                free_mask[i] = 1'b1;
            end
            if (!tbl_valid[i] && !alloc_found) begin
                alloc_found   = 1'b1;
                alloc_mask[i] = 1'b1;
            end
        end
    end

    assign can_issue = !fifo_empty && (outstanding_count < 5'(MAX_OUT)) && !tag_busy;

    // Issue FSM; the head stays put until the data handshake pops it.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state         <= IDLE;
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (can_issue) begin
                    state         <= INSTR;
                    instr_valid_q <= 1'b1;
                end
                INSTR: if (lsu_proc_instr_ready) begin
                    state         <= DATA;
                    instr_valid_q <= 1'b0;
                    data_valid_q  <= 1'b1;
                end
                DATA: if (lsu_proc_data_ready) begin
                    state        <= IDLE;
                    data_valid_q <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    instr_valid_q <= 1'b0;
                    data_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding table. Issue was gated on a free slot, so a pop always
    // finds one; the freed slot is distinct from the allocated one.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            tbl_valid         <= '0;
            outstanding_count <= '0;
        end else begin
            tbl_valid         <= (tbl_valid & ~free_mask) | (pop ? alloc_mask : '0);
            outstanding_count <= outstanding_count + {4'b0, pop} - {4'b0, hit};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUT; i++) begin
            if (pop && alloc_mask[i]) begin
                tbl_tag[i]      <= head.tag;
                tbl_is_write[i] <= head.is_write;
            end
        end
    end

    // Completion forwarding: one-cycle latency, no backpressure.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            resp_valid         <= 1'b0;
            resp_is_write      <= 1'b0;
            resp_tag           <= '0;
            resp_value         <= '0;
            err_unexpected_tag <= 1'b0;
        end else begin
            resp_valid         <= hit;
            err_unexpected_tag <= lsu_completion_valid && !hit;
            if (hit) begin
                resp_is_write <= hit_is_write;
                resp_tag      <= lsu_completion_tag;
                resp_value    <= lsu_completion_value;
            end
        end
    end

    assign lsu_proc_instr_valid    = instr_valid_q;
    assign lsu_proc_data_valid     = data_valid_q;
    assign lsu_proc_instr_is_write = head.is_write;
    assign lsu_proc_instr_tag      = head.tag;
    assign lsu_proc_data_tag       = head.tag;
    assign lsu_proc_addr           = head.addr;
    assign lsu_proc_value          = head.value;

endmodule

// File: tb/tb_lsu_request_issuer.sv
// Self-checking bench for lsu_request_issuer: directed scenarios plus a
// randomized phase, compared every cycle against a queue-based model.

module tb_lsu_request_issuer;

    localparam int TW      = 10;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic          clk = 1'b0;
    logic          rst_N;
    logic          req_valid, req_ready, req_is_write;
    logic [TW-1:0] req_tag;
    logic [63:0]   req_addr, req_value;
    logic          instr_valid, instr_is_write, instr_ready;
    logic [TW-1:0] instr_tag;
    logic          data_valid, data_ready;
    logic [TW-1:0] data_tag;
    logic [63:0]   p_addr, p_value;
    logic          cpl_valid;
    logic [TW-1:0] cpl_tag;
    logic [63:0]   cpl_value;
    logic          resp_valid, resp_is_write, err;
    logic [TW-1:0] resp_tag;
    logic [63:0]   resp_value;
    logic [4:0]    out_cnt;

    int checks = 0;
    int errors = 0;

    lsu_request_issuer #(.TAG_WIDTH(TW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_N(rst_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
        .req_tag(req_tag), .req_addr(req_addr), .req_value(req_value),
        .lsu_proc_instr_valid(instr_valid), .lsu_proc_instr_is_write(instr_is_write),
        .lsu_proc_instr_tag(instr_tag), .lsu_proc_instr_ready(instr_ready),
        .lsu_proc_data_valid(data_valid), .lsu_proc_data_tag(data_tag),
        .lsu_proc_addr(p_addr), .lsu_proc_value(p_value), .lsu_proc_data_ready(data_ready),
        .lsu_completion_valid(cpl_valid), .lsu_completion_tag(cpl_tag),
        .lsu_completion_value(cpl_value),
        .resp_valid(resp_valid), .resp_is_write(resp_is_write), .resp_tag(resp_tag),
        .resp_value(resp_value), .err_unexpected_tag(err), .outstanding_count(out_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [TW-1:0] tag;
        logic          w;
        logic [63:0]   addr;
        logic [63:0]   value;
    } mreq_t;
    typedef struct {
        logic [TW-1:0] tag;
        logic          w;
    } ment_t;

    mreq_t         m_fifo[$];
    ment_t         m_tbl[$];
    int            m_phase = 0;    // 0 waiting to issue, 1 instr phase, 2 data phase
    logic          m_resp_valid = 1'b0, m_resp_w = 1'b0, m_err = 1'b0;
    logic [TW-1:0] m_resp_tag = '0;
    logic [63:0]   m_resp_value = '0;

    always @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            m_fifo.delete();
            m_tbl.delete();
            m_phase      = 0;
            m_resp_valid = 1'b0;
            m_resp_w     = 1'b0;
            m_err        = 1'b0;
            m_resp_tag   = '0;
            m_resp_value = '0;
        end else begin : model_step
            bit    accept, busy, retire;
            int    idx, nxt;
            ment_t ent;
            accept = req_valid && (m_fifo.size() < DEPTH);
            busy   = 1'b0;
            if (m_fifo.size() > 0)
                foreach (m_tbl[i]) if (m_tbl[i].tag == m_fifo[0].tag) busy = 1'b1;
            idx = -1;
            if (cpl_valid)
                foreach (m_tbl[i]) if (m_tbl[i].tag == cpl_tag) idx = i;
            m_resp_valid = (idx >= 0);
            m_err        = cpl_valid && (idx < 0);
            if (idx >= 0) begin
                m_resp_tag   = cpl_tag;
                m_resp_value = cpl_value;
                m_resp_w     = m_tbl[idx].w;
            end
            nxt    = m_phase;
            retire = 1'b0;
            ent    = '{tag: '0, w: 1'b0};
            case (m_phase)
                0: if (m_fifo.size() > 0 && m_tbl.size() < MAX_OUT && !busy) nxt = 1;
                1: if (instr_ready) nxt = 2;
                2: if (data_ready) begin
                    nxt    = 0;
                    retire = 1'b1;
                    ent    = '{tag: m_fifo[0].tag, w: m_fifo[0].w};
                end
                default: nxt = 0;
            endcase
            m_phase = nxt;
            if (idx >= 0) m_tbl.delete(idx);
            if (retire) begin
                m_tbl.push_back(ent);
                void'(m_fifo.pop_front());
            end
            if (accept)
                m_fifo.push_back('{tag: req_tag, w: req_is_write, addr: req_addr, value: req_value});
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (rst_N === 1'b1) begin
            check("req_ready", 64'(req_ready), 64'(m_fifo.size() < DEPTH));
            check("instr_valid", 64'(instr_valid), 64'(m_phase == 1));
            check("data_valid", 64'(data_valid), 64'(m_phase == 2));
            check("outstanding_count", 64'(out_cnt), 64'(m_tbl.size()));
            check("resp_valid", 64'(resp_valid), 64'(m_resp_valid));
            check("err_unexpected_tag", 64'(err), 64'(m_err));
            if (m_resp_valid) begin
                check("resp_tag", 64'(resp_tag), 64'(m_resp_tag));
                check("resp_value", resp_value, m_resp_value);
                check("resp_is_write", 64'(resp_is_write), 64'(m_resp_w));
            end
            if (m_fifo.size() > 0) begin
                check("instr_tag", 64'(instr_tag), 64'(m_fifo[0].tag));
                check("instr_is_write", 64'(instr_is_write), 64'(m_fifo[0].w));
                check("data_tag", 64'(data_tag), 64'(m_fifo[0].tag));
                check("addr", p_addr, m_fifo[0].addr);
                check("value", p_value, m_fifo[0].value);
            end else begin
                check("instr_tag_empty", 64'(instr_tag), 64'd0);
                check("addr_empty", p_addr, 64'd0);
                check("value_empty", p_value, 64'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [TW-1:0] tag, input logic w,
                        input logic [63:0] a, input logic [63:0] v);
        bit acc = 1'b0;
        req_valid = 1'b1; req_tag = tag; req_is_write = w; req_addr = a; req_value = v;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("push_accepted", 64'(acc), 64'd1);
    endtask

    task automatic complete(input logic [TW-1:0] tag, input logic [63:0] v);
        cpl_valid = 1'b1; cpl_tag = tag; cpl_value = v;
        @(negedge clk);
        cpl_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        req_valid = 1'b0; instr_ready = 1'b1; data_ready = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (m_fifo.size() == 0 && m_phase == 0 && m_tbl.size() == 0) begin
                done = 1'b1;
            end else begin
                cpl_valid = (m_tbl.size() > 0);
                if (m_tbl.size() > 0) cpl_tag = m_tbl[0].tag;
                cpl_value = {$urandom, $urandom};
                @(negedge clk);
            end
        end
        cpl_valid = 1'b0;
        check("drain_done", 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_N = 1'b0;
        req_valid = 1'b0; req_is_write = 1'b0; req_tag = '0; req_addr = '0; req_value = '0;
        instr_ready = 1'b1; data_ready = 1'b1;
        cpl_valid = 1'b0; cpl_tag = '0; cpl_value = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_count", 64'(out_cnt), 64'd0);
        rst_N = 1'b1;
        @(negedge clk);

        // Single store, minimum latency path.
        push(10'd10, 1'b1, 64'h1000, 64'hDEADBEEFCAFEF00D);
        @(negedge clk);
        check("store_instr_valid_e1", 64'(instr_valid), 64'd1);
        @(negedge clk);
        check("store_data_valid_e2", 64'(data_valid), 64'd1);
        check("store_instr_low_e2", 64'(instr_valid), 64'd0);
        @(negedge clk);
        check("store_count_e3", 64'(out_cnt), 64'd1);
        check("store_data_low_e3", 64'(data_valid), 64'd0);
        complete(10'd10, 64'h1234);
        check("store_resp_valid", 64'(resp_valid), 64'd1);
        check("store_resp_is_write", 64'(resp_is_write), 64'd1);
        check("store_count_after", 64'(out_cnt), 64'd0);

        // Load returning a value.
        push(10'd20, 1'b0, 64'h1000, 64'h5555);
        repeat (4) @(negedge clk);
        complete(10'd20, 64'hDEADBEEFCAFEF00D);
        check("load_resp_tag", 64'(resp_tag), 64'd20);
        check("load_resp_value", resp_value, 64'hDEADBEEFCAFEF00D);
        check("load_resp_is_write", 64'(resp_is_write), 64'd0);

        // Fill the FIFO while the instruction phase is stalled.
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_tag = TW'(30 + k); req_is_write = k[0];
            req_addr = 64'(k) << 4; req_value = 64'(k) + 64'h100;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("full_req_ready", 64'(req_ready), 64'd0);
        check("stall_instr_valid", 64'(instr_valid), 64'd1);
        check("stall_instr_tag", 64'(instr_tag), 64'd30);
        repeat (3) @(negedge clk);
        check("stall_instr_tag_held", 64'(instr_tag), 64'd30);
        drain();

        // Concurrency cap: tag 3 waits until tag 1 completes.
        push(10'd1, 1'b0, 64'h10, 64'h0);
        push(10'd2, 1'b1, 64'h20, 64'h2);
        push(10'd3, 1'b0, 64'h30, 64'h0);
        repeat (12) @(negedge clk);
        check("cap_count", 64'(out_cnt), 64'd2);
        check("cap_blocked", 64'(instr_valid), 64'd0);
        check("cap_head", 64'(instr_tag), 64'd3);
        complete(10'd1, 64'h77);
        check("cap_release_e0", 64'(instr_valid), 64'd0);
        @(negedge clk);
        check("cap_release_e1", 64'(instr_valid), 64'd1);
        drain();

        // Duplicate tag waits for the first to complete.
        push(10'd7, 1'b0, 64'h70, 64'h0);
        push(10'd7, 1'b1, 64'h71, 64'h7);
        repeat (10) @(negedge clk);
        check("dup_count", 64'(out_cnt), 64'd1);
        check("dup_blocked", 64'(instr_valid), 64'd0);
        complete(10'd7, 64'h99);
        check("dup_still_blocked", 64'(instr_valid), 64'd0);
        @(negedge clk);
        check("dup_issue", 64'(instr_valid), 64'd1);
        drain();

        // Completion for a tag never issued.
        complete(10'd99, 64'h42);
        check("bad_tag_err", 64'(err), 64'd1);
        check("bad_tag_no_resp", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("bad_tag_err_pulse", 64'(err), 64'd0);

        // Reset during the data phase.
        data_ready = 1'b0;
        push(10'd40, 1'b1, 64'h4000, 64'hABCD);
        for (int i = 0; i < 20 && !data_valid; i++) @(negedge clk);
        check("reach_data_phase", 64'(data_valid), 64'd1);
        #2 rst_N = 1'b0;
        #1;
        check("async_rst_req_ready", 64'(req_ready), 64'd1);
        check("async_rst_instr", 64'(instr_valid), 64'd0);
        check("async_rst_data", 64'(data_valid), 64'd0);
        check("async_rst_addr", p_addr, 64'd0);
        check("async_rst_tag", 64'(data_tag), 64'd0);
        check("async_rst_count", 64'(out_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_N = 1'b1;
        data_ready = 1'b1;
        @(negedge clk);
        complete(10'd40, 64'h1);
        check("abandoned_err", 64'(err), 64'd1);
        check("abandoned_no_resp", 64'(resp_valid), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            int r;
            req_valid    = ($urandom_range(0, 99) < 50);
            req_tag      = TW'($urandom_range(0, 7));
            req_is_write = 1'($urandom_range(0, 1));
            req_addr     = {$urandom, $urandom};
            req_value    = {$urandom, $urandom};
            instr_ready  = ($urandom_range(0, 99) < 70);
            data_ready   = ($urandom_range(0, 99) < 70);
            cpl_value    = {$urandom, $urandom};
            r = int'($urandom_range(0, 99));
            if (r < 35 && m_tbl.size() > 0) begin
                cpl_valid = 1'b1;
                cpl_tag   = m_tbl[$urandom_range(0, m_tbl.size() - 1)].tag;
            end else if (r < 40) begin
                cpl_valid = 1'b1;
                cpl_tag   = TW'($urandom_range(0, 15));
            end else begin
                cpl_valid = 1'b0;
            end
            @(negedge clk);
        end
        cpl_valid = 1'b0;
        drain();
        check("final_count", 64'(out_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
